query_block_dispatcher: RTL
===========================

QUERY_BLOCK_DISPATCHER -- requirements
Module: query_block_dispatcher

Interface
REQ-001 SHALL have parameter NUM_PES, default 64, number of PEs; one query block = 2*NUM_PES bits.
REQ-002 SHALL have ports:
- clk  in  1  engine clock
- rst  in  1  reset, synchronous, active-high
- query_info_valid  in  1  query info valid
- query_info_rdy  out  1  query info ready
- ref_length  in  28  reference length
- ref_addr  in  28  reference address
- num_query_blocks  in  16  blocks in query
- query_id  in  16  query ID
- cell_score_threshold  in  32  reporting threshold
- query_seq_block_valid  in  1  block valid
- query_seq_block_rdy  out  1  block ready
- query_seq_block  in  2*NUM_PES  query block
- pe_query_load  out  1  one-cycle load strobe to PE array
- pe_query_block  out  2*NUM_PES  block presented to PE array
- ref_req_valid  out  1  reference stream request valid
- ref_req_rdy  in  1  request accepted
- ref_req_addr  out  28  held ref_addr
- ref_req_length  out  28  held ref_length
- job_query_id  out  16  held query_id
- job_block_idx  out  16  index of the current block
- job_threshold  out  32  held threshold
- engine_done  in  1  PE array finished current block (pulse)
- query_done  out  1  one-cycle pulse, last block finished
- busy  out  1  state != IDLE

Function
REQ-003 Transfer occurs on a rising clk edge with valid=1 and rdy=1; rdy SHALL be a function of registered state only, never of valid.
REQ-004 States: IDLE, WAIT_BLOCK, ISSUE_REQ, RUN.
REQ-005 IDLE: query_info_rdy=1; on info transfer, latch ref_length, ref_addr, num_query_blocks, query_id, cell_score_threshold; job_block_idx<=0; next WAIT_BLOCK.
REQ-006 IDLE with num_query_blocks=0 on transfer: info consumed, no block accepted, query_done pulses next cycle, stay IDLE.
REQ-007 WAIT_BLOCK: query_seq_block_rdy=1; on transfer, pe_query_block<=query_seq_block, pe_query_load=1 in the following cycle only; next ISSUE_REQ.
REQ-008 ISSUE_REQ: ref_req_valid=1 with ref_req_addr/length, job_* stable; on ref_req_rdy=1, next RUN; otherwise hold all outputs.
REQ-009 RUN: wait engine_done; if job_block_idx == latched num_query_blocks-1, query_done=1 the next cycle and next IDLE; else job_block_idx+1, next WAIT_BLOCK.
REQ-010 Blocks per query exactly num_query_blocks (1..65535); job_block_idx 16-bit, no wrap within a query.
REQ-011 query_info_rdy SHALL be 0 outside IDLE; query_seq_block_rdy SHALL be 0 outside WAIT_BLOCK; block/info valids in other states ignored and not consumed.
REQ-012 engine_done outside RUN ignored; engine_done in the same cycle as ref_req transfer ignored.
REQ-013 Minimum per-block latency: block transfer -> ref_req_valid next cycle; ref_req transfer -> earliest counted engine_done the cycle after.
REQ-014 pe_query_block and job_* SHALL change only on their latching transfers; stable otherwise.
REQ-015 Back-to-back queries: query_info_rdy=1 the cycle after the final RUN exits.

Reset
REQ-016 rst=1 at a clock edge: state IDLE; query_info_rdy=1 in next cycle; query_seq_block_rdy, pe_query_load, ref_req_valid, query_done, busy=0; pe_query_block, ref_req_addr, ref_req_length, job_*=0.
REQ-017 rst mid-query SHALL abandon the query without query_done; partial block/request discarded.

Verification
REQ-018 Single query N=1, addr=0x100, len=0x2000, id=7: info, one block, ref_req_rdy=1, engine_done -> one pe_query_load, one request (addr 0x100, len 0x2000, id 7, idx 0), query_done once, busy returns 0.
REQ-019 N=3, ref_req_rdy delayed 5 cycles each -> ref_req_valid held 6 cycles per block, job_block_idx 0,1,2, exactly 3 loads, query_done after third engine_done.
REQ-020 Block valid asserted during RUN -> query_seq_block_rdy=0, block not consumed until WAIT_BLOCK; spurious engine_done in WAIT_BLOCK -> no state change.
REQ-021 N=0 info -> no block accepted, query_done pulse, next info accepted immediately.
REQ-022 rst asserted in RUN at block 1 of 4 -> all outputs at reset values next cycle, no query_done; new query then completes normally.
REQ-023 Two queries back-to-back (id 1 N=2, id 2 N=1) with info valid held high -> second info accepted the cycle after first query_done, job_query_id switches 1->2.

Source files
------------

// File: rtl/query_block_dispatcher_if.sv
// Handshake and data bundle between the query host, the reference streamer, the PE array
// and the query block dispatcher.
interface query_block_dispatcher_if #(
    parameter int NUM_PES = 64
);
    logic                   query_info_valid;
    logic                   query_info_rdy;
    logic [27:0]            ref_length;
    logic [27:0]            ref_addr;
    logic [15:0]            num_query_blocks;
    logic [15:0]            query_id;
    logic [31:0]            cell_score_threshold;
    logic                   query_seq_block_valid;
    logic                   query_seq_block_rdy;
    logic [2*NUM_PES-1:0]   query_seq_block;
    logic                   pe_query_load;
    logic [2*NUM_PES-1:0]   pe_query_block;
    logic                   ref_req_valid;
    logic                   ref_req_rdy;
    logic [27:0]            ref_req_addr;
    logic [27:0]            ref_req_length;
    logic [15:0]            job_query_id;
    logic [15:0]            job_block_idx;
    logic [31:0]            job_threshold;
    logic                   engine_done;
    logic                   query_done;
    logic                   busy;

    // Everything outside the dispatcher: host, reference streamer and PE array.
    modport master (
        output query_info_valid, ref_length, ref_addr, num_query_blocks, query_id,
               cell_score_threshold, query_seq_block_valid, query_seq_block,
               ref_req_rdy, engine_done,
        input  query_info_rdy, query_seq_block_rdy, pe_query_load, pe_query_block,
               ref_req_valid, ref_req_addr, ref_req_length, job_query_id,
               job_block_idx, job_threshold, query_done, busy
    );

    modport slave (
        input  query_info_valid, ref_length, ref_addr, num_query_blocks, query_id,
               cell_score_threshold, query_seq_block_valid, query_seq_block,
               ref_req_rdy, engine_done,
        output query_info_rdy, query_seq_block_rdy, pe_query_load, pe_query_block,
               ref_req_valid, ref_req_addr, ref_req_length, job_query_id,
               job_block_idx, job_threshold, query_done, busy
    );
endinterface

// File: rtl/query_block_dispatcher.sv
// Sequences a query block by block: accept query info, then per block load the PE array,
// issue one reference stream request and wait for the engine to finish.
module query_block_dispatcher #(
    parameter int NUM_PES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    query_block_dispatcher_if.slave  qb
);
    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, ISSUE_REQ, RUN} state_t;

    state_t               state_reg, state_next;
    logic [27:0]          ref_length_reg, ref_addr_reg;
    logic [15:0]          num_blocks_reg, query_id_reg, block_idx_reg;
    logic [31:0]          threshold_reg;
    logic [2*NUM_PES-1:0] pe_block_reg;
    logic                 load_reg, done_reg;

    logic info_rdy, block_rdy, req_valid;
    logic info_xfer, block_xfer, run_finish, last_block;

    assign info_xfer  = info_rdy && qb.query_info_valid;
    assign block_xfer = block_rdy && qb.query_seq_block_valid;
    // engine_done only counts in RUN, so a pulse coinciding with the request handshake is dropped.
    assign run_finish = (state_reg == RUN) && qb.engine_done;
    assign last_block = (block_idx_reg == (num_blocks_reg - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        info_rdy   = 1'b0;
        block_rdy  = 1'b0;
        req_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                info_rdy = 1'b1;
                // An empty query is consumed in place and only produces query_done.
                if (qb.query_info_valid && (qb.num_query_blocks != 16'd0))
                    state_next = WAIT_BLOCK;
            end
            WAIT_BLOCK: begin
                block_rdy = 1'b1;
                if (qb.query_seq_block_valid) state_next = ISSUE_REQ;
            end
            ISSUE_REQ: begin
                req_valid = 1'b1;
                if (qb.ref_req_rdy) state_next = RUN;
            end
            RUN: begin
                if (qb.engine_done) state_next = last_block ? IDLE : WAIT_BLOCK;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_length_reg <= '0;
            ref_addr_reg   <= '0;
            num_blocks_reg <= '0;
            query_id_reg   <= '0;
            threshold_reg  <= '0;
            block_idx_reg  <= '0;
            pe_block_reg   <= '0;
            load_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            load_reg <= block_xfer;
            done_reg <= (info_xfer && (qb.num_query_blocks == 16'd0)) || (run_finish && last_block);
            if (info_xfer) begin
                ref_length_reg <= qb.ref_length;
                ref_addr_reg   <= qb.ref_addr;
                num_blocks_reg <= qb.num_query_blocks;
                query_id_reg   <= qb.query_id;
                threshold_reg  <= qb.cell_score_threshold;
                block_idx_reg  <= '0;
            end
            if (block_xfer) pe_block_reg <= qb.query_seq_block;
            if (run_finish && !last_block) block_idx_reg <= block_idx_reg + 16'd1;
        end
    end

    assign qb.query_info_rdy      = info_rdy;
    assign qb.query_seq_block_rdy = block_rdy;
    assign qb.ref_req_valid       = req_valid;
    assign qb.busy                = (state_reg != IDLE);
    assign qb.pe_query_load       = load_reg;
    assign qb.pe_query_block      = pe_block_reg;
    assign qb.query_done          = done_reg;
    assign qb.ref_req_addr        = ref_addr_reg;
    assign qb.ref_req_length      = ref_length_reg;
    assign qb.job_query_id        = query_id_reg;
    assign qb.job_block_idx       = block_idx_reg;
    assign qb.job_threshold       = threshold_reg;
endmodule
